alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (32-bit, 3-bit ALUControl, Zero flag) between two requesters.
//  Round-robin arbitration; registered operands drive the ALU; registered result is returned
//  on a valid/ready response channel tagged with the winning requester id.
//  Sits between the core's integer datapath and an auxiliary unit (e.g. address/loop engine).
// PARAMETERS
//  WIDTH  32  operand/result width, must match the shared ALU
//  OPW    3   ALU control width, must match the shared ALU
// PORTS
//  clk         in   1      rising-edge clock
//  reset_n     in   1      asynchronous active-low reset
//  req0_valid  in   1      requester 0 has an operation
//  req0_ready  out  1      requester 0 operation accepted this cycle (valid & ready)
//  req0_a      in   WIDTH  requester 0 operand a
//  req0_b      in   WIDTH  requester 0 operand b
//  req0_op     in   OPW    requester 0 ALU control code
//  req1_*      same as req0_* for requester 1
//  alu_a       out  WIDTH  to shared ALU input a
//  alu_b       out  WIDTH  to shared ALU input b
//  alu_ctrl    out  OPW    to shared ALU ALUControl
//  alu_result  in   WIDTH  from shared ALU ALUResult
//  alu_zero    in   1      from shared ALU Zero
//  rsp_valid   out  1      response available
//  rsp_ready   in   1      consumer takes response
//  rsp_data    out  WIDTH  captured ALU result
//  rsp_zero    out  1      captured Zero flag
//  rsp_id      out  1      requester that issued the operation (0/1)
//  rsp_err     out  1      illegal op code flagged (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, all outputs 0, last_grant=1 (req0 wins first tie).
//  - FSM: IDLE -> EXEC -> RESP -> IDLE. One operation in flight.
//  - IDLE: if any reqN_valid, grant per round-robin: both valid -> grant != last_grant;
//    one valid -> that one. reqN_ready=1 combinationally only for the granted requester,
//    only in IDLE. On grant: latch a,b,op,id into operand regs, last_grant<=id, go EXEC.
//  - EXEC (1 cycle): alu_a/alu_b/alu_ctrl driven from operand regs (driven from regs in
//    all states, stable after EXEC). Capture alu_result->rsp_data, alu_zero->rsp_zero; go RESP.
//  - RESP: rsp_valid=1; rsp_data/zero/id/err stable until rsp_valid&rsp_ready; then IDLE.
//  - Latency: accept at edge T, rsp_valid high from T+2; min period 3 cycles per operation.
//  - No new accept while EXEC/RESP; reqN_ready=0. Requesters hold fields stable until ready.
//  - Non-granted requester keeps valid; served next IDLE (no starvation: alternates under contention).
//  - Reset mid-operation: in-flight operation dropped, no response, rsp_valid=0 immediately.
//  - No arithmetic in this block; widths pass through unmodified.
// CONFIGURATION
//  ALU_OP_CHECK_EN defined: op legal only in {000,001,010,110,111}; illegal op accepted
//    normally, EXEC skips capture, response has rsp_err=1, rsp_data=0, rsp_zero=0,
//    same 2-cycle latency; alu_ctrl still shows latched op.
//  Not defined: no checking, rsp_err tied 0, result is whatever the ALU returns.
// TESTING
//  1 req0 a=5 b=3 op=010, rsp_ready=1 -> req0_ready cycle 0, rsp_valid cycle 2, data=8, zero=0, id=0.
//  2 both valid after reset: req0 (a=7,b=7,op=110), req1 (a=1,b=2,op=111) -> req0 first
//    (data=0, zero=1), req1 next accept (data=1, id=1); then again both -> req0 granted (alternates).
//  3 backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid/data held, req*_ready=0;
//    rsp_ready=1 -> back to IDLE, next accept following cycle.
//  4 reset_n low during EXEC -> rsp_valid=0, outputs 0, no response; next req0 served normally.
//  5 ALU_OP_CHECK_EN: op=011 -> rsp_err=1, data=0; without macro -> rsp_err=0, data=ALU output.
//  6 req1 only valid continuously, 10 ops (a=i,b=1,op=010) -> results 1..10, ids all 1, 3-cycle spacing.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Optional op-code legality check: define ALU_OP_CHECK_EN to flag illegal ALU control codes.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters hold valid and their fields stable until ready; ready never waits on
  // anything but the arbiter state, and the response stays stable until rsp_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic             any_valid;
  logic             accept;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~req0_valid;
    end
    accept     = (state == IDLE) && any_valid;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q        <= grant_id ? req1_a  : req0_a;
        b_q        <= grant_id ? req1_b  : req0_b;
        op_q       <= grant_id ? req1_op : req0_op;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
    end
  end

`ifdef ALU_OP_CHECK_EN
  logic op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OPW'(0), OPW'(1), OPW'(2), OPW'(6), OPW'(7): op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  end

  // An illegal op still walks the full pipeline so latency is identical; only capture is suppressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == EXEC) begin
      if (op_legal) begin
        rsp_data <= alu_result;
        rsp_zero <= alu_zero;
        rsp_err  <= 1'b0;
      end else begin
        rsp_data <= '0;
        rsp_zero <= 1'b0;
        rsp_err  <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= alu_result;
      rsp_zero <= alu_zero;
    end
  end

  assign rsp_err = 1'b0;
`endif

  // The ALU always sees the latched operands, so its inputs stay quiet outside a grant.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = op_q;
  assign rsp_id    = id_q;
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
    !(req0_ready && req1_ready));

  a_no_accept_busy: assert property (@(posedge clk) disable iff (!reset_n)
    (state != IDLE) |-> !(req0_ready || req1_ready));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_zero)
                                   && $stable(rsp_id) && $stable(rsp_err)));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural model of the shared ALU.
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req0_ready;
  logic [W-1:0]  req0_a, req0_b;
  logic [OW-1:0] req0_op;
  logic          req1_valid, req1_ready;
  logic [W-1:0]  req1_a, req1_b;
  logic [OW-1:0] req1_op;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [OW-1:0] alu_ctrl;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_zero, rsp_id, rsp_err;
  logic [1:0]    dbg_state;

  int vec_count = 0;
  int err_count = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  alu_share_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Shared ALU model; undefined codes return a marker so pass-through is visible.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == '0);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b0) begin err_count++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    vec_count++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin err_count++; $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); end
    vec_count++; if (alu_a !== '0 || alu_b !== '0 || alu_ctrl !== '0) begin err_count++; $display("FAIL rst_alu: got %h %h %b want 0", alu_a, alu_b, alu_ctrl); end
    vec_count++; if (rsp_data !== '0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin err_count++; $display("FAIL rst_rsp: got %h %b %b %b want 0", rsp_data, rsp_zero, rsp_id, rsp_err); end
    vec_count++; if (dbg_state !== 2'd0) begin err_count++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_op();
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b010; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    vec_count++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin err_count++; $display("FAIL single_grant: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk); req0_valid = 1'b0; #1;
    vec_count++; if (dbg_state !== 2'd1 || rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin err_count++; $display("FAIL single_exec: got st=%0d v=%b r=%b want 1 0 0", dbg_state, rsp_valid, req0_ready); end
    vec_count++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_ctrl !== 3'b010) begin err_count++; $display("FAIL single_alu_in: got %0d %0d %b want 5 3 010", alu_a, alu_b, alu_ctrl); end
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd8) begin err_count++; $display("FAIL single_rsp: got v=%b d=%0d want 1 8", rsp_valid, rsp_data); end
    vec_count++; if (rsp_zero !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin err_count++; $display("FAIL single_flags: got z=%b id=%b e=%b want 0 0 0", rsp_zero, rsp_id, rsp_err); end
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin err_count++; $display("FAIL single_done: got v=%b st=%0d want 0 0", rsp_valid, dbg_state); end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    req0_a = 32'd7; req0_b = 32'd7; req0_op = 3'b110;
    req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'b111;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    vec_count++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin err_count++; $display("FAIL rr_first: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk); req0_valid = 1'b0; #1;
    vec_count++; if (req1_ready !== 1'b0) begin err_count++; $display("FAIL rr_exec_block: got %b want 0", req1_ready); end
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b0) begin err_count++; $display("FAIL rr_rsp0: got v=%b d=%0d z=%b id=%b want 1 0 1 0", rsp_valid, rsp_data, rsp_zero, rsp_id); end
    vec_count++; if (req1_ready !== 1'b0) begin err_count++; $display("FAIL rr_resp_block: got %b want 0", req1_ready); end
    next_cycle();
    vec_count++; if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin err_count++; $display("FAIL rr_second_grant: got r1=%b v=%b want 1 0", req1_ready, rsp_valid); end
    @(negedge clk); req1_valid = 1'b0; #1;
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || rsp_zero !== 1'b0 || rsp_id !== 1'b1) begin err_count++; $display("FAIL rr_rsp1: got v=%b d=%0d z=%b id=%b want 1 1 0 1", rsp_valid, rsp_data, rsp_zero, rsp_id); end
    next_cycle();
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    vec_count++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin err_count++; $display("FAIL rr_alt0: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk); req0_valid = 1'b0; #1;
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin err_count++; $display("FAIL rr_alt0_rsp: got v=%b id=%b want 1 0", rsp_valid, rsp_id); end
    next_cycle();
    vec_count++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin err_count++; $display("FAIL rr_alt1: got %b%b want 01", req0_ready, req1_ready); end
    @(negedge clk); req1_valid = 1'b0; #1;
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd1) begin err_count++; $display("FAIL rr_alt1_rsp: got v=%b id=%b d=%0d want 1 1 1", rsp_valid, rsp_id, rsp_data); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    req0_a = 32'd10; req0_b = 32'd4; req0_op = 3'b110; req0_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    vec_count++; if (req0_ready !== 1'b1) begin err_count++; $display("FAIL bp_grant: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_a = 32'd3; req1_b = 32'd3; req1_op = 3'b000; req1_valid = 1'b1;
    #1;
    vec_count++; if (req1_ready !== 1'b0) begin err_count++; $display("FAIL bp_exec_block: got %b want 0", req1_ready); end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd6 || rsp_err !== 1'b0) begin err_count++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d e=%b want 1 6 0", i, rsp_valid, rsp_data, rsp_err); end
      vec_count++; if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin err_count++; $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready); end
      next_cycle();
    end
    vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd6) begin err_count++; $display("FAIL bp_hold_end: got v=%b d=%0d want 1 6", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin err_count++; $display("FAIL bp_release: got v=%b r1=%b want 0 1", rsp_valid, req1_ready); end
    @(negedge clk); req1_valid = 1'b0; #1;
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd3 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin err_count++; $display("FAIL bp_next_rsp: got v=%b d=%0d id=%b e=%b want 1 3 1 0", rsp_valid, rsp_data, rsp_id, rsp_err); end
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b010; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    vec_count++; if (req0_ready !== 1'b1) begin err_count++; $display("FAIL mid_grant: got %b want 1", req0_ready); end
    @(negedge clk); req0_valid = 1'b0; #1;
    vec_count++; if (dbg_state !== 2'd1) begin err_count++; $display("FAIL mid_exec: got %0d want 1", dbg_state); end
    reset_n = 1'b0; #1;
    vec_count++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0 || alu_a !== '0 || alu_ctrl !== '0) begin err_count++; $display("FAIL mid_async: got v=%b st=%0d a=%0d op=%b want 0 0 0 0", rsp_valid, dbg_state, alu_a, alu_ctrl); end
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      vec_count++; if (rsp_valid !== 1'b0) begin err_count++; $display("FAIL mid_no_rsp[%0d]: got %b want 0", i, rsp_valid); end
    end
    req0_a = 32'd20; req0_b = 32'd22; req0_op = 3'b010; req0_valid = 1'b1; #1;
    vec_count++; if (req0_ready !== 1'b1) begin err_count++; $display("FAIL mid_regrant: got %b want 1", req0_ready); end
    @(negedge clk); req0_valid = 1'b0; #1;
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || rsp_id !== 1'b0) begin err_count++; $display("FAIL mid_after_rsp: got v=%b d=%0d id=%b want 1 42 0", rsp_valid, rsp_data, rsp_id); end
    next_cycle();
  endtask

  task automatic test_illegal_op();
    logic [W-1:0] exp_data;
    logic         exp_err;
`ifdef ALU_OP_CHECK_EN
    exp_data = 32'd0;
    exp_err  = 1'b1;
`else
    exp_data = 32'hDEAD_BEEF;
    exp_err  = 1'b0;
`endif
    req1_a = 32'd9; req1_b = 32'd4; req1_op = 3'b011; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    vec_count++; if (req1_ready !== 1'b1) begin err_count++; $display("FAIL ill_grant: got %b want 1", req1_ready); end
    @(negedge clk); req1_valid = 1'b0; #1;
    vec_count++; if (alu_ctrl !== 3'b011) begin err_count++; $display("FAIL ill_ctrl: got %b want 011", alu_ctrl); end
    next_cycle();
    vec_count++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== exp_err) begin err_count++; $display("FAIL ill_rsp: got v=%b d=%h e=%b want 1 %h %b", rsp_valid, rsp_data, rsp_err, exp_data, exp_err); end
    vec_count++; if (rsp_zero !== 1'b0 || rsp_id !== 1'b1) begin err_count++; $display("FAIL ill_flags: got z=%b id=%b want 0 1", rsp_zero, rsp_id); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int acc      = 0;
    int rsp_n    = 0;
    int last_acc = 0;
    int cyc      = 0;
    bit acc_now;
    logic [W-1:0] exp;
    req1_a = 32'd0; req1_b = 32'd1; req1_op = 3'b010; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    while (rsp_n < 10 && cyc < 100) begin
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vec_count++; err_count++;
          $display("FAIL b2b_unexpected_rsp: got d=%0d want no response", rsp_data);
        end else begin
          exp = exp_q.pop_front();
          vec_count++; if (rsp_data !== exp || rsp_id !== 1'b1) begin err_count++; $display("FAIL b2b_rsp[%0d]: got d=%0d id=%b want %0d 1", rsp_n, rsp_data, rsp_id, exp); end
        end
        rsp_n++;
      end
      acc_now = req1_ready;
      if (acc_now) begin
        if (acc > 0) begin
          vec_count++; if (cyc - last_acc != 3) begin err_count++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", acc, cyc - last_acc); end
        end
        last_acc = cyc;
        exp_q.push_back(W'(acc + 1));
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        if (acc == 10) req1_valid = 1'b0;
        else req1_a = W'(acc);
      end
      #1;
    end
    vec_count++; if (rsp_n != 10 || acc != 10) begin err_count++; $display("FAIL b2b_count: got rsp=%0d acc=%0d want 10 10", rsp_n, acc); end
    req1_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_illegal_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
